// File: rtl/i2s_rx.sv
//==============================================================================
// Module   : i2s_rx
// Purpose  : I2S receiver. Oversamples an external I2S stream (SCLK/LRCK/SDATA)
//            in the clk_74a domain and recovers left/right samples of
//            SAMPLE_BITS bits each. Frame format: 32 SCLK per slot, MSB first,
//            data delayed one SCLK after the LRCK edge, LRCK=0 is the left
//            slot. SCLK is treated as data, never as a clock.
// Ports    : clk_74a      - system clock, the only clock in the block
//            reset_n      - asynchronous active-low reset, released synchronously
//            i2s_sclk     - I2S bit clock, asynchronous to clk_74a
//            i2s_lrck     - I2S word select, 0 = left, 1 = right
//            i2s_data     - I2S serial data
//            left_audio   - last complete left sample (two's complement)
//            right_audio  - last complete right sample, paired with left_audio
//            sample_valid - 1-cycle pulse: a new stereo pair was loaded
//            frame_error  - 1-cycle pulse: a slot ended short of SAMPLE_BITS bits
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2s_rx #(
    parameter int SAMPLE_BITS = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_74a,
    input  logic                   reset_n,
    input  logic                   i2s_sclk,
    input  logic                   i2s_lrck,
    input  logic                   i2s_data,
    output logic [SAMPLE_BITS-1:0] left_audio,
    output logic [SAMPLE_BITS-1:0] right_audio,
    output logic                   sample_valid,
    output logic                   frame_error
);

    localparam int                c_CNT_W = $clog2(SAMPLE_BITS + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(SAMPLE_BITS);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(SAMPLE_BITS - 1);

    // Synchronizers: shift in at bit 0, synced value taken from the top bit.
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_lrck_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_sclk_d;

    logic                   w_sclk_s;
    logic                   w_lrck_s;
    logic                   w_data_s;
    logic                   w_rise;

    // Rise strobe and its data/lrck, registered once so the capture logic
    // starts from flops rather than from the synchronizer outputs.
    logic                   r_rise_q;
    logic                   r_lrck_q;
    logic                   r_data_q;

    // Slot capture state
    logic                   r_lrck_prev;
    logic                   r_locked;
    logic                   r_chan;
    logic                   r_left_ok;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic [SAMPLE_BITS-1:0] r_shift;
    logic [SAMPLE_BITS-1:0] r_left_hold;
    logic                   r_pair_evt;
    logic                   r_err_evt;

    logic                   w_boundary;
    logic                   w_capture;
    logic                   w_word_done;
    logic [SAMPLE_BITS-1:0] w_word;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_lrck_s = r_lrck_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_rise   = w_sclk_s & ~r_sclk_d;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_lrck_sync <= '0;
            r_data_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_rise_q    <= 1'b0;
            r_lrck_q    <= 1'b0;
            r_data_q    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i2s_sclk};
            r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i2s_data};
            r_sclk_d    <= w_sclk_s;
            r_rise_q    <= w_rise;
            r_lrck_q    <= w_lrck_s;
            r_data_q    <= w_data_s;
        end
    end

    // An LRCK change seen at a rise marks a slot boundary; that rise carries
    // the previous slot's last bit, so it is never shifted in.
    assign w_boundary  = (r_lrck_q != r_lrck_prev);
    assign w_capture   = !w_boundary && r_locked && (r_bit_cnt != c_FULL);
    assign w_word      = {r_shift[SAMPLE_BITS-2:0], r_data_q};
    assign w_word_done = w_capture && (r_bit_cnt == c_LAST);

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_lrck_prev <= 1'b0;
            r_locked    <= 1'b0;
            r_chan      <= 1'b0;
            r_left_ok   <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_left_hold <= '0;
            r_pair_evt  <= 1'b0;
            r_err_evt   <= 1'b0;
        end else begin
            r_pair_evt <= 1'b0;
            r_err_evt  <= 1'b0;
            if (r_rise_q) begin
                r_lrck_prev <= r_lrck_q;
                if (w_boundary) begin
                    // A short slot only counts once we know where slots begin.
                    if (r_locked && (r_bit_cnt != c_FULL)) begin
                        r_err_evt <= 1'b1;
                        r_left_ok <= 1'b0;
                    end
                    r_bit_cnt <= '0;
                    r_shift   <= '0;
                    r_chan    <= r_lrck_q;
                    r_locked  <= 1'b1;
                end else if (w_capture) begin
                    r_shift   <= w_word;
                    r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                    if (w_word_done) begin
                        if (!r_chan) begin
                            r_left_hold <= w_word;
                            r_left_ok   <= 1'b1;
                        end else begin
                            // A right word without a preceding left word is
                            // dropped quietly: it is the tail of a lock-in.
                            r_pair_evt <= r_left_ok;
                            r_left_ok  <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Output stage: r_shift still holds the completed right word here, as
    // the next boundary is many clk_74a cycles away.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            left_audio   <= '0;
            right_audio  <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            sample_valid <= r_pair_evt;
            frame_error  <= r_err_evt;
            if (r_pair_evt) begin
                left_audio  <= r_left_hold;
                right_audio <= r_shift;
            end
        end
    end

endmodule

`default_nettype wire
